// File: rtl/rv32_pkg.sv
// Shared RV32I constants and the {pc, instr} record carried by the fetch stage.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; a pop on a full queue makes room for a push in the same cycle.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full && !do_pop && !flush));
  end

endmodule

// File: rtl/fetch_cycle.sv
// RV32I IF stage: credit-limited req/gnt/rvalid fetch into a prefetch queue feeding the IF/ID register.
module fetch_cycle import rv32_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int              QUEUE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            stall_d_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc4_d,
  output logic            valid_d
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   t_count;
  logic [CW-1:0]   discard;
  logic [CW:0]     credit_used;
  logic            q_full, q_empty, t_full, t_empty;
  logic            fire, drop, q_push, q_pop;
  logic [XLEN-1:0] tag_pc;
  fetch_entry_t    q_din, q_dout;

  // Queued entries plus in-flight requests may never exceed the queue size.
  assign credit_used = {1'b0, q_count} + {1'b0, t_count};
  assign imem_req_o  = !rst && !redirect_i && (credit_used < (CW+1)'(QUEUE_DEPTH));
  assign imem_addr_o = fetch_pc;
  assign fire        = imem_req_o && imem_gnt_i;

  assign drop   = redirect_i || (discard != '0);
  assign q_push = imem_rvalid_i && !drop;
  assign q_pop  = !redirect_i && !stall_d_i && !q_empty;
  assign q_din  = '{pc: tag_pc, instr: imem_rdata_i};

  // Tags are not flushed on redirect: discarded responses drain them in order.
  fetch_queue #(.WIDTH(XLEN), .DEPTH(QUEUE_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fire),
    .pop   (imem_rvalid_i),
    .flush (1'b0),
    .din   (fetch_pc),
    .dout  (tag_pc),
    .count (t_count),
    .full  (t_full),
    .empty (t_empty)
  );

  fetch_queue #(.WIDTH(2*XLEN), .DEPTH(QUEUE_DEPTH)) u_instr_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_i),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             fetch_pc <= RESET_PC;
    else if (redirect_i) fetch_pc <= redirect_pc_i;
    else if (fire)       fetch_pc <= fetch_pc + 32'd4;
  end

  // Outstanding already includes earlier discards, so the new total is simply what remains in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  discard <= '0;
    else if (redirect_i)                      discard <= t_count - CW'(imem_rvalid_i);
    else if (imem_rvalid_i && discard != '0)  discard <= discard - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d <= NOP_INSTR;
      pc_d    <= '0;
      pc4_d   <= '0;
      valid_d <= 1'b0;
    end else if (redirect_i) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (!stall_d_i) begin
      if (!q_empty) begin
        instr_d <= q_dout.instr;
        pc_d    <= q_dout.pc;
        pc4_d   <= q_dout.pc + 32'd4;
        valid_d <= 1'b1;
      end else begin
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(q_push && q_full && !q_pop));
      assert (!(fire && t_full && !imem_rvalid_i));
      assert (!(imem_rvalid_i && t_empty));
    end
  end

endmodule

// File: tb/tb_fetch_cycle.sv
// Directed-plus-random bench for fetch_cycle: in-order memory model with random grant/latency and a program-order stream scoreboard.
module tb_fetch_cycle;
  import rv32_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // main instance
  logic        req, gnt, rvalid, stall, redirect, valid_d;
  logic [31:0] addr, rdata, rpc, instr_d, pc_d, pc4_d;
  // wrap-around instance
  logic        req2, gnt2, rvalid2, valid2;
  logic [31:0] addr2, rdata2, instr2, pc2, pc42;

  fetch_cycle u_dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .stall_d_i     (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (rpc),
    .instr_d       (instr_d),
    .pc_d          (pc_d),
    .pc4_d         (pc4_d),
    .valid_d       (valid_d)
  );

  fetch_cycle #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (req2),
    .imem_addr_o   (addr2),
    .imem_gnt_i    (gnt2),
    .imem_rvalid_i (rvalid2),
    .imem_rdata_i  (rdata2),
    .stall_d_i     (1'b0),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .instr_d       (instr2),
    .pc_d          (pc2),
    .pc4_d         (pc42),
    .valid_d       (valid2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int new_instr = 0;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  int gnt_pct = 100;
  int lat_min = 1;
  int lat_max = 1;

  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];
  logic        prev_stall, prev_redirect;
  logic [31:0] prev_rpc;
  logic [31:0] last_instr, last_pc, last_pc4;
  logic        last_valid;
  logic        last_req2;
  logic [31:0] last_addr2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs after an edge, judged by the inputs that edge saw.
  task automatic check_outputs();
    logic [31:0] p;
    if (prev_redirect) begin
      chk("redir_valid", 32'(valid_d), 32'd0);
      chk("redir_instr", instr_d, NOP_INSTR);
      chk("redir_pc_hold", pc_d, last_pc);
      chk("redir_pc4_hold", pc4_d, last_pc4);
      exp_pc = prev_rpc;
    end else if (prev_stall) begin
      chk("stall_instr", instr_d, last_instr);
      chk("stall_pc", pc_d, last_pc);
      chk("stall_pc4", pc4_d, last_pc4);
      chk("stall_valid", 32'(valid_d), 32'(last_valid));
    end else if (valid_d) begin
      chk("pc_d", pc_d, exp_pc);
      chk("instr_d", instr_d, exp_pc ^ KEY);
      chk("pc4_d", pc4_d, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      new_instr++;
    end else begin
      chk("bubble_instr", instr_d, NOP_INSTR);
      chk("bubble_pc_hold", pc_d, last_pc);
    end
    if (valid2 && exp_q.size() > 0) begin
      p = exp_q.pop_front();
      chk("wrap_pc", pc2, p);
      chk("wrap_pc4", pc42, p + 32'd4);
      chk("wrap_instr", instr2, p ^ KEY);
    end
  endtask

  // One clock: drive memory responses, record grants, advance, check.
  task automatic tick();
    gnt    = ($urandom_range(99) < 32'(gnt_pct));
    rvalid = (pend.size() > 0) && (pend[0].due <= cyc);
    rdata  = rvalid ? (pend[0].addr ^ KEY) : $urandom;
    rvalid2 = last_req2;
    rdata2  = last_addr2 ^ KEY;
    #1;
    if (rvalid) pend.delete(0);
    if (req && gnt) pend.push_back('{addr: addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
    last_req2  = req2;
    last_addr2 = addr2;
    prev_stall    = stall;
    prev_redirect = redirect;
    prev_rpc      = rpc;
    last_instr = instr_d;
    last_pc    = pc_d;
    last_pc4   = pc4_d;
    last_valid = valid_d;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  initial begin
    int first;
    int n0;
    logic found;

    rst = 1'b1;
    stall = 1'b0; redirect = 1'b0; rpc = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    gnt2 = 1'b1; rvalid2 = 1'b0; rdata2 = '0;
    last_req2 = 1'b0; last_addr2 = '0;
    prev_stall = 1'b0; prev_redirect = 1'b0; prev_rpc = '0;
    repeat (2) @(negedge clk);

    chk("rst_req", 32'(req), 32'd0);
    chk("rst_valid", 32'(valid_d), 32'd0);
    chk("rst_instr", instr_d, NOP_INSTR);
    chk("rst_pc", pc_d, 32'd0);
    chk("rst_pc4", pc4_d, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wrap_addr", addr2, 32'hFFFF_FFF8);

    rst = 1'b0;
    exp_pc = 32'd0;
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};

    // Step 1: always-grant, 1-cycle memory: first valid after the 3rd edge, then one per cycle.
    first = -1;
    for (int i = 0; i < 6 && first < 0; i++) begin
      tick();
      if (valid_d) first = i + 1;
    end
    chk("first_valid_edge", 32'(first), 32'd3);
    repeat (4) tick();
    chk("pc_before_stall", pc_d, 32'h10);
    chk("throughput_count", 32'(new_instr), 32'd5);

    // Step 2: 3-cycle stall at pc 0x10; queue fills and the request drops.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_pc", pc_d, 32'h10);
    end
    chk("stall_req_drop", 32'(req), 32'd0);
    stall = 1'b0;
    tick();
    chk("after_stall_pc", pc_d, 32'h14);

    // Step 3: redirect to 0x200 with two requests in flight.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() >= 2) found = 1'b1;
      else tick();
    end
    chk("redir_setup", 32'(found), 32'd1);
    redirect = 1'b1; rpc = 32'h200;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 30 && !valid_d; i++) tick();
    chk("redir_first_pc", valid_d ? pc_d : 32'hDEAD_BEEF, 32'h200);

    // Step 4: redirect + stall + response in the same cycle.
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() >= 2 && pend[0].due <= cyc) found = 1'b1;
      else tick();
    end
    chk("combo_setup", 32'(found), 32'd1);
    stall = 1'b1; redirect = 1'b1; rpc = 32'h400;
    tick();
    stall = 1'b0; redirect = 1'b0;
    for (int i = 0; i < 30 && !valid_d; i++) tick();
    chk("combo_first_pc", valid_d ? pc_d : 32'hDEAD_BEEF, 32'h400);

    // Step 5: random grant, latency, stalls and redirects.
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    n0 = new_instr;
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(99) < 20);
      redirect = ($urandom_range(99) < 4);
      rpc      = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    stall = 1'b0; redirect = 1'b0; gnt_pct = 100;
    repeat (20) tick();
    chk("random_progress", 32'(new_instr - n0 > 100), 32'd1);
    chk("drain_valid", 32'(valid_d), 32'd1);
    chk("wrap_all_seen", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
